// File: rtl/ibexc_rvfi_trace_buf.sv
// RVFI retirement-trace buffer: captures one record per retired instruction into a
// FIFO and serialises each record as five 32-bit words on a valid/ready stream.
module ibexc_rvfi_trace_buf #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned DropCntW = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        rvfi_valid,
    input  logic [31:0]                 rvfi_pc_rdata,
    input  logic [31:0]                 rvfi_insn,
    input  logic                        rvfi_trap,
    input  logic                        rvfi_intr,
    input  logic [4:0]                  rvfi_rd_addr,
    input  logic [31:0]                 rvfi_rd_wdata,
    input  logic [31:0]                 rvfi_mem_addr,
    input  logic [3:0]                  rvfi_mem_rmask,
    input  logic [3:0]                  rvfi_mem_wmask,
    input  logic                        rvfi_mem_is_cap,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [31:0]                 trace_data_o,
    output logic                        trace_last_o,
    input  logic                        clr_drop_i,
    output logic [DropCntW-1:0]         drop_cnt_o,
    output logic [$clog2(Depth):0]      fill_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullLvl = (AW+1)'(Depth);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic        trap;
        logic        intr;
        logic        is_cap;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [4:0]  rd_addr;
        logic        ovf;
    } entry_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    entry_t              mem [Depth];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         fill_q, fill_d;
    logic [2:0]          widx_q;
    state_e              state_q, state_d;
    logic                ovf_pend_q;
    logic [DropCntW-1:0] drop_cnt_q;

    logic   push_req, push, pop, drop, hs;
    entry_t head, new_entry;
    logic   [31:0] word;

    assign trace_valid_o = (state_q == SEND);
    assign hs            = trace_valid_o & trace_ready_i;
    assign pop           = hs & (widx_q == 3'd4);
    assign push_req      = en_i & rvfi_valid;
    // A full FIFO still accepts when the head's final word leaves this cycle.
    assign push          = push_req & ((fill_q < FullLvl) | pop);
    assign drop          = push_req & ~push;

    always_comb begin
        new_entry          = '0;
        new_entry.pc       = rvfi_pc_rdata;
        new_entry.insn     = rvfi_insn;
        new_entry.rd_wdata = rvfi_rd_wdata;
        new_entry.mem_addr = rvfi_mem_addr;
        new_entry.trap     = rvfi_trap;
        new_entry.intr     = rvfi_intr;
        new_entry.is_cap   = rvfi_mem_is_cap;
        new_entry.rmask    = rvfi_mem_rmask;
        new_entry.wmask    = rvfi_mem_wmask;
        new_entry.rd_addr  = rvfi_rd_addr;
        new_entry.ovf      = ovf_pend_q;
    end

    always_comb begin
        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (!push && pop) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_d != '0) state_d = SEND;
            SEND:    if (pop && fill_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            widx_q     <= '0;
            ovf_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                ovf_pend_q <= 1'b0;
            end else if (drop) begin
                ovf_pend_q <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (hs) begin
                widx_q <= (widx_q == 3'd4) ? 3'd0 : widx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (clr_drop_i) begin
            drop_cnt_q <= drop ? DropCntW'(1) : '0;
        end else if (drop && drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign head = mem[rd_ptr_q];

    always_comb begin
        word = '0;
        case (widx_q)
            3'd0: word = {8'hA5, 3'b000, head.ovf, head.trap, head.intr, head.is_cap, 1'b0,
                          head.rmask, head.wmask, 3'b000, head.rd_addr};
            3'd1: word = head.pc;
            3'd2: word = head.insn;
            3'd3: word = head.rd_wdata;
            3'd4: word = head.mem_addr;
            default: word = '0;
        endcase
    end

    assign trace_data_o = trace_valid_o ? word : '0;
    assign trace_last_o = trace_valid_o & (widx_q == 3'd4);
    assign drop_cnt_o   = drop_cnt_q;
    assign fill_o       = fill_q;

endmodule

// File: tb/tb_ibexc_rvfi_trace_buf.sv
// Self-checking bench for ibexc_rvfi_trace_buf: table-driven records plus
// multi-cycle corner sequences, with a word-level scoreboard on the trace stream.
module tb_ibexc_rvfi_trace_buf;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DCW   = 4;

    logic        clk_i = 1'b0;
    logic        rst_i, en_i, rvfi_valid;
    logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, rvfi_mem_addr;
    logic        rvfi_trap, rvfi_intr, rvfi_mem_is_cap;
    logic [4:0]  rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        trace_valid_o, trace_ready_i, trace_last_o, clr_drop_i;
    logic [31:0] trace_data_o;
    logic [DCW-1:0] drop_cnt_o;
    logic [$clog2(DEPTH):0] fill_o;

    ibexc_rvfi_trace_buf #(.Depth(DEPTH), .DropCntW(DCW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .rvfi_valid(rvfi_valid),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_intr(rvfi_intr), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_is_cap(rvfi_mem_is_cap),
        .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
        .trace_data_o(trace_data_o), .trace_last_o(trace_last_o),
        .clr_drop_i(clr_drop_i), .drop_cnt_o(drop_cnt_o), .fill_o(fill_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc, insn, wdata, maddr;
        logic        trap, intr, cap;
        logic [3:0]  rmask, wmask;
        logic [4:0]  rd;
        logic [31:0] w0;
    } tv_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } sb_t;

    sb_t q[$];
    int  nchecks = 0;
    int  nerrors = 0;
    bit  model_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic tv_t gen(input int unsigned i);
        tv_t t;
        t.pc    = 32'h8000_1000 + (i << 2);
        t.insn  = 32'h0000_0013 | (i << 20);
        t.wdata = 32'hC0DE_0000 + i;
        t.maddr = 32'h2000_0000 + (i << 4);
        t.trap  = i[0];
        t.intr  = i[1];
        t.cap   = i[2];
        t.rmask = i[3:0];
        t.wmask = ~i[3:0];
        t.rd    = i[4:0];
        t.w0    = {8'hA5, 3'b000, 1'b0, t.trap, t.intr, t.cap, 1'b0,
                   t.rmask, t.wmask, 3'b000, t.rd};
        return t;
    endfunction

    // mode: 0 = ignored, 1 = expected accepted, 2 = expected dropped
    task automatic retire(input tv_t t, input int mode);
        rvfi_pc_rdata   = t.pc;
        rvfi_insn       = t.insn;
        rvfi_rd_wdata   = t.wdata;
        rvfi_mem_addr   = t.maddr;
        rvfi_trap       = t.trap;
        rvfi_intr       = t.intr;
        rvfi_mem_is_cap = t.cap;
        rvfi_mem_rmask  = t.rmask;
        rvfi_mem_wmask  = t.wmask;
        rvfi_rd_addr    = t.rd;
        rvfi_valid      = 1'b1;
        if (mode == 1) begin
            q.push_back('{t.w0 | (model_ovf ? 32'h0010_0000 : 32'h0), 1'b0});
            q.push_back('{t.pc, 1'b0});
            q.push_back('{t.insn, 1'b0});
            q.push_back('{t.wdata, 1'b0});
            q.push_back('{t.maddr, 1'b1});
            model_ovf = 1'b0;
        end else if (mode == 2) begin
            model_ovf = 1'b1;
        end
        step();
        rvfi_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && fill_o == '0 && !trace_valid_o) break;
            step();
        end
        chk(name, {31'b0, (q.size() == 0 && fill_o == '0 && !trace_valid_o)}, 32'd1);
    endtask

    // Stream monitor: compares every handshake against the scoreboard and checks
    // that a stalled word stays put until accepted.
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_d = '0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", {31'b0, trace_valid_o}, 32'd1);
                chk("hold_data", trace_data_o, prev_d);
            end
            if (trace_valid_o && trace_ready_i) begin
                if (q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL extra_word: got %h expected none", trace_data_o);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    chk("stream_data", trace_data_o, e.data);
                    chk("stream_last", {31'b0, trace_last_o}, {31'b0, e.last});
                end
            end
            prev_v = trace_valid_o;
            prev_r = trace_ready_i;
            prev_d = trace_data_o;
        end
    end

    initial begin
        tv_t vecs[4];
        int  n;
        vecs[0] = '{pc: 32'h8000_0040, insn: 32'h0000_0013, wdata: 32'h0000_1234, maddr: 32'h0,
                    trap: 0, intr: 0, cap: 0, rmask: 4'h0, wmask: 4'h0, rd: 5'd5, w0: 32'hA500_0005};
        vecs[1] = '{pc: 32'h0000_1000, insn: 32'h0010_2083, wdata: 32'hDEAD_BEEF, maddr: 32'h2000_0010,
                    trap: 1, intr: 0, cap: 0, rmask: 4'hF, wmask: 4'h0, rd: 5'd0, w0: 32'hA508_F000};
        vecs[2] = '{pc: 32'h8000_0100, insn: 32'h00A1_2023, wdata: 32'h0, maddr: 32'h1000_0004,
                    trap: 0, intr: 1, cap: 1, rmask: 4'h0, wmask: 4'h3, rd: 5'd31, w0: 32'hA506_031F};
        vecs[3] = '{pc: 32'hFFFF_FFFC, insn: 32'hFFFF_FFFF, wdata: 32'h8000_0000, maddr: 32'hFFFF_FFFF,
                    trap: 1, intr: 1, cap: 1, rmask: 4'h5, wmask: 4'hA, rd: 5'd10, w0: 32'hA50E_5A0A};

        rst_i = 1'b1; en_i = 1'b1; rvfi_valid = 1'b0; trace_ready_i = 1'b0; clr_drop_i = 1'b0;
        rvfi_pc_rdata = '0; rvfi_insn = '0; rvfi_rd_wdata = '0; rvfi_mem_addr = '0;
        rvfi_trap = 0; rvfi_intr = 0; rvfi_mem_is_cap = 0; rvfi_rd_addr = '0;
        rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
        repeat (3) step();
        chk("rst_valid", {31'b0, trace_valid_o}, 32'd0);
        chk("rst_data", trace_data_o, 32'd0);
        chk("rst_last", {31'b0, trace_last_o}, 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("rst_fill", 32'(fill_o), 32'd0);
        rst_i = 1'b0;
        step();

        // Table-driven single records with ready held high.
        trace_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            retire(vecs[i], 1);
            chk("latency_valid", {31'b0, trace_valid_o}, 32'd1);
            chk("latency_w0", trace_data_o, vecs[i].w0);
            chk("fill_after_push", 32'(fill_o), 32'd1);
            wait_drain("table_drain", 20);
            chk("table_fill0", 32'(fill_o), 32'd0);
        end

        // Backpressure: ready pattern 1,0,0 repeating.
        trace_ready_i = 1'b0;
        retire(vecs[3], 1);
        n = 0;
        while ((q.size() != 0 || trace_valid_o) && n < 60) begin
            trace_ready_i = (n % 3 == 0);
            step();
            n++;
        end
        trace_ready_i = 1'b1;
        wait_drain("bp_drain", 10);

        // Overflow: 10 retirements into a stalled 8-deep FIFO.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) retire(gen(i), (i < 8) ? 1 : 2);
        chk("ovf_fill", 32'(fill_o), 32'd8);
        chk("ovf_drop", 32'(drop_cnt_o), 32'd2);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (fill_o < 8) break;
            step();
        end
        chk("ovf_space", {31'b0, (fill_o < 8)}, 32'd1);
        retire(gen(20), 1);
        wait_drain("ovf_drain", 80);
        chk("ovf_drop_kept", 32'(drop_cnt_o), 32'd2);

        // Full FIFO with a retirement landing on the W4 handshake.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) retire(gen(30 + i), 1);
        chk("full_fill", 32'(fill_o), 32'd8);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (trace_last_o) break;
            step();
        end
        chk("full_at_w4", {31'b0, trace_last_o}, 32'd1);
        retire(gen(40), 1);
        chk("full_pop_fill", 32'(fill_o), 32'd8);
        chk("full_pop_drop", 32'(drop_cnt_o), 32'd2);
        wait_drain("full_drain", 80);

        // Saturation, clear, clear-with-drop, and capture disable.
        clr_drop_i = 1'b1;
        step();
        clr_drop_i = 1'b0;
        chk("clr_drop", 32'(drop_cnt_o), 32'd0);
        trace_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) retire(gen(50 + i), 1);
        for (int i = 0; i < 15; i++) retire(gen(60), 2);
        chk("sat_reach", 32'(drop_cnt_o), 32'hF);
        retire(gen(61), 2);
        chk("sat_hold", 32'(drop_cnt_o), 32'hF);
        clr_drop_i = 1'b1;
        retire(gen(62), 2);
        clr_drop_i = 1'b0;
        chk("clr_with_drop", 32'(drop_cnt_o), 32'd1);
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) retire(gen(63), 0);
        chk("dis_drop", 32'(drop_cnt_o), 32'd1);
        chk("dis_fill", 32'(fill_o), 32'd8);
        en_i = 1'b1;
        trace_ready_i = 1'b1;
        wait_drain("sat_drain", 80);

        // Reset mid-record with three entries queued.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) retire(gen(70 + i), 1);
        chk("mid_fill", 32'(fill_o), 32'd3);
        trace_ready_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b1;
        step();
        q.delete();
        model_ovf = 1'b0;
        rst_i = 1'b0;
        chk("mid_rst_valid", {31'b0, trace_valid_o}, 32'd0);
        chk("mid_rst_data", trace_data_o, 32'd0);
        chk("mid_rst_last", {31'b0, trace_last_o}, 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("mid_rst_fill", 32'(fill_o), 32'd0);
        step();
        retire(vecs[0], 1);
        chk("post_rst_w0", trace_data_o, 32'hA500_0005);
        wait_drain("post_rst_drain", 20);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/ibexc_rvfi_trace_buf.md
# ibexc_rvfi_trace_buf

Retirement-trace capture buffer sitting directly downstream of the RVFI outputs of the traced CHERIoT Ibex top. It samples one record per retired instruction (`rvfi_valid`) into a small FIFO and drains each record as a 5-word, 32-bit valid/ready stream toward an off-core trace sink. The buffer decouples bursty retirement from a slow sink, counts records dropped on overflow, and flags the first record following any loss.

## Interface
Parameters:
- `Depth`, 8: FIFO entries; power of two, ≥2.
- `DropCntW`, 16: drop-counter width.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: synchronous, active-high reset.
- `en_i` in 1: capture enable; when 0, retirements are ignored and not counted as drops.
- `rvfi_valid` in 1: retirement strobe.
- `rvfi_pc_rdata` in 32: retiring PC.
- `rvfi_insn` in 32: instruction word.
- `rvfi_trap` in 1: trap flag.
- `rvfi_intr` in 1: interrupt flag.
- `rvfi_rd_addr` in 5: destination register.
- `rvfi_rd_wdata` in 32: destination write data.
- `rvfi_mem_addr` in 32: memory address.
- `rvfi_mem_rmask` in 4: memory read mask.
- `rvfi_mem_wmask` in 4: memory write mask.
- `rvfi_mem_is_cap` in 1: capability memory access.
- `trace_valid_o` out 1: stream word valid.
- `trace_ready_i` in 1: sink accepts the word.
- `trace_data_o` out 32: stream word.
- `trace_last_o` out 1: last word (W4) of a record.
- `clr_drop_i` in 1: clears the drop counter.
- `drop_cnt_o` out `DropCntW`: saturating count of dropped records.
- `fill_o` out `$clog2(Depth)+1`: FIFO occupancy.

## Operation
- Entry (145 bits): pc, insn, rd_wdata, mem_addr, trap, intr, is_cap, rmask, wmask, rd_addr, ovf.
- Push: requires `en_i & rvfi_valid`.
  - Accepted when `fill_o < Depth`, or when `fill_o == Depth` and a pop (final-word handshake) occurs in the same cycle.
  - Otherwise the record is dropped: `drop_cnt_o` increments, saturating at all-ones, and the `ovf_pend` flag is set.
- `ovf_pend` is copied into the ovf bit of the next accepted entry, then cleared. A drop in the same cycle as an accepted push cannot occur, because there is one record per cycle.
- `clr_drop_i` sets the counter to 0. If a drop happens in the same cycle, the counter becomes 1. `clr_drop_i` does not affect `ovf_pend`.
- Serializer: word index `widx` counts 0..4, and the FSM has two states.
  - IDLE: entered when the FIFO is empty.
  - SEND: `trace_valid_o` = 1 and `trace_data_o` = word[`widx`] of the head entry.
  - A handshake (`valid & ready`) advances `widx`.
  - At `widx` = 4, a handshake pops the head and sets `widx` to 0. The FSM stays in SEND if more entries remain, else returns to IDLE.
- Word format:
  - W0 = {8'hA5, 3'b0, ovf, trap, intr, is_cap, 1'b0, rmask, wmask, 3'b0, rd_addr}.
  - W1 = pc, W2 = insn, W3 = rd_wdata, W4 = mem_addr.
- `trace_last_o` = (`widx` == 4) & `trace_valid_o`.
- Stream rules:
  - Once `trace_valid_o` is high, it and `trace_data_o` hold stable until the handshake.
  - Valid never depends combinationally on `trace_ready_i`.
- Pointers wrap modulo `Depth`. `fill_o` = pushes minus pops, and never exceeds `Depth`.

## Timing
- Reset: FIFO empty, `widx` = 0, IDLE, `ovf_pend` = 0. All outputs 0: `trace_valid_o`, `trace_data_o`, `trace_last_o`, `drop_cnt_o`, `fill_o`.
- Reset mid-record abandons the record and discards all entries. No partial record is resumed after reset.
- Latency: a push sampled at edge N gives `trace_valid_o` = 1 with W0 in cycle N+1 (registered FIFO state; no bypass).
- Throughput: 5 cycles per record with `trace_ready_i` held high. Back-to-back records have no bubble: W4 of record k is followed immediately by W0 of record k+1.
- Drop counter and `fill_o` update on the edge following the event.

## Test plan
- Single record: pc=0x8000_0040, insn=0x0000_0013, rd=5, wdata=0x1234, mem 0, ready=1.
  - Cycles N+1..N+5 produce 0xA500_0005, 0x8000_0040, 0x0000_0013, 0x0000_1234, 0x0.
  - `trace_last_o` is high only on the fifth word; `fill_o` returns to 0.
- Backpressure: ready toggled 1,0,0,1,… during a record.
  - Data and valid hold steady while ready is 0.
  - The exact 5-word sequence is delivered with no duplicate and no skip.
- Overflow: `Depth`=8, ready=0, 10 consecutive retirements.
  - `fill_o`=8 and `drop_cnt_o`=2.
  - Set ready=1 and retire one more: 9 records stream out, and only the ninth record's W0 has bit 20 (ovf) set.
- Full with simultaneous pop: fill=8, and a retirement lands in the W4-handshake cycle.
  - The record is accepted, `fill_o` stays 8, and `drop_cnt_o` is unchanged.
- Saturation and clear:
  - Force `drop_cnt_o`=0xFFFF, then drop again: it stays 0xFFFF.
  - `clr_drop_i` together with a drop gives `drop_cnt_o`=1.
  - With `en_i`=0, retirements leave the counter and FIFO unchanged.
- Reset mid-record: assert `rst_i` after W2 is accepted with 3 entries queued.
  - Next cycle all outputs are 0 and `fill_o`=0.
  - A new retirement streams starting from W0.
